// File: rtl/evm_tally.sv
// Vote tally for a 4-candidate poll: counts locked votes, picks the winner on close,
// then streams per-candidate counts over a valid/ready result port.
module evm_tally #(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned MAX_VOTES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vote_valid,
  input  logic [1:0]       vote_option,
  input  logic             poll_close,
  input  logic             poll_open,
  input  logic             res_ready,
  output logic             vote_ack,
  output logic             vote_reject,
  output logic             res_valid,
  output logic [1:0]       res_cand,
  output logic [CNT_W-1:0] res_count,
  output logic             res_last,
  output logic [1:0]       winner,
  output logic             winner_valid,
  output logic             tie,
  output logic [CNT_W-1:0] total_votes,
  output logic             full,
  output logic             poll_active
);

  localparam int unsigned NUM_CAND = 4;

  typedef enum logic [1:0] {
    S_OPEN   = 2'd0,
    S_CLOSED = 2'd1,
    S_REPORT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_CAND];
  logic [1:0]       beat_q;
  logic [1:0]       win_c;
  logic             tie_c;
  logic [CNT_W-1:0] best_c;
  logic [2:0]       n_max_c;
  logic             accept_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_OPEN;
    else        state_q <= state_d;
  end

  // Next-state logic; a vote in the closing cycle is still counted by the datapath
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OPEN:   if (poll_close) state_d = S_CLOSED;
      S_CLOSED: state_d = S_REPORT;
      S_REPORT: if (res_ready && beat_q == 2'd3) state_d = S_DONE;
      S_DONE:   if (poll_open) state_d = S_OPEN;
      default:  state_d = S_OPEN;
    endcase
  end

  // Winner search: strict greater-than keeps the lowest index on ties
  always_comb begin
    win_c   = 2'd0;
    best_c  = cnt_q[0];
    n_max_c = 3'd0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (cnt_q[i] > best_c) begin
        best_c = cnt_q[i];
        win_c  = 2'(i);
      end
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      if (cnt_q[i] == best_c) n_max_c = n_max_c + 3'd1;
    end
    tie_c = (n_max_c >= 3'd2);
  end

  assign full     = (total_votes == CNT_W'(MAX_VOTES));
  assign accept_c = vote_valid && (state_q == S_OPEN) && !full;

  // Counters, vote responses and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
      total_votes  <= '0;
      beat_q       <= 2'd0;
      winner       <= 2'd0;
      tie          <= 1'b0;
      winner_valid <= 1'b0;
      vote_ack     <= 1'b0;
      vote_reject  <= 1'b0;
    end else begin
      vote_ack    <= accept_c;
      vote_reject <= vote_valid && !accept_c;
      if (accept_c) begin
        cnt_q[vote_option] <= cnt_q[vote_option] + CNT_W'(1);
        total_votes        <= total_votes + CNT_W'(1);
      end
      case (state_q)
        S_CLOSED: begin
          winner       <= win_c;
          tie          <= tie_c;
          winner_valid <= 1'b1;
          beat_q       <= 2'd0;
        end
        S_REPORT: begin
          if (res_ready) beat_q <= beat_q + 2'd1;
        end
        S_DONE: begin
          if (poll_open) begin
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
            total_votes  <= '0;
            winner       <= 2'd0;
            tie          <= 1'b0;
            winner_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign poll_active = (state_q == S_OPEN);
  assign res_valid   = (state_q == S_REPORT);
  assign res_cand    = res_valid ? beat_q : 2'd0;
  assign res_count   = res_valid ? cnt_q[beat_q] : '0;
  assign res_last    = res_valid && (beat_q == 2'd3);

endmodule

// File: tb/tb_evm_tally.sv
// Scoreboard bench for evm_tally: a poll-level model predicts vote responses,
// result beats and the final winner/tie/total; a negedge monitor checks them.
module tb_evm_tally;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned MAX_VOTES = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             vote_valid, poll_close, poll_open, res_ready;
  logic [1:0]       vote_option;
  logic             vote_ack, vote_reject, res_valid, res_last;
  logic [1:0]       res_cand, winner;
  logic [CNT_W-1:0] res_count, total_votes;
  logic             winner_valid, tie, full, poll_active;

  evm_tally #(.CNT_W(CNT_W), .MAX_VOTES(MAX_VOTES)) dut (
    .clk(clk), .reset(reset), .vote_valid(vote_valid), .vote_option(vote_option),
    .poll_close(poll_close), .poll_open(poll_open), .res_ready(res_ready),
    .vote_ack(vote_ack), .vote_reject(vote_reject), .res_valid(res_valid),
    .res_cand(res_cand), .res_count(res_count), .res_last(res_last),
    .winner(winner), .winner_valid(winner_valid), .tie(tie),
    .total_votes(total_votes), .full(full), .poll_active(poll_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cand;
    int cnt;
    int last;
  } beat_t;

  int    checks = 0;
  int    failures = 0;
  int    exp_vote [$];
  beat_t exp_beats [$];

  // Poll model: phase 0=voting, 1=results pending, 2=finished
  int m_cnt [4];
  int m_total;
  int m_phase;
  int m_win;
  int m_tie;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_total = 0;
    m_phase = 0;
    m_win   = 0;
    m_tie   = 0;
  endtask

  task automatic model_close();
    int best;
    int n;
    beat_t b;
    best = -1;
    n    = 0;
    for (int i = 0; i < 4; i++)
      if (m_cnt[i] > best) begin best = m_cnt[i]; m_win = i; end
    for (int i = 0; i < 4; i++) if (m_cnt[i] == best) n++;
    m_tie = (n >= 2) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      b.cand = i; b.cnt = m_cnt[i]; b.last = (i == 3) ? 1 : 0;
      exp_beats.push_back(b);
    end
    m_phase = 1;
  endtask

  task automatic vote(input int opt, input int cls);
    vote_valid  = 1'b1;
    vote_option = 2'(opt);
    poll_close  = (cls != 0);
    if (m_phase == 0 && m_total < int'(MAX_VOTES)) begin
      m_cnt[opt]++;
      m_total++;
      exp_vote.push_back(1);
    end else begin
      exp_vote.push_back(0);
    end
    if (cls != 0 && m_phase == 0) model_close();
    step();
    vote_valid = 1'b0;
    poll_close = 1'b0;
  endtask

  task automatic close_poll();
    poll_close = 1'b1;
    if (m_phase == 0) model_close();
    step();
    poll_close = 1'b0;
  endtask

  task automatic open_poll();
    poll_open = 1'b1;
    if (m_phase == 2) model_clear();
    step();
    poll_open = 1'b0;
  endtask

  task automatic check_done();
    chk("done_res_valid", res_valid, 0);
    chk("done_poll_active", poll_active, 0);
    chk("done_winner_valid", winner_valid, 1);
    chk("done_winner", winner, m_win);
    chk("done_tie", tie, m_tie);
    chk("done_total", total_votes, m_total);
    chk("done_full", full, (m_total == int'(MAX_VOTES)) ? 1 : 0);
  endtask

  // Drain result beats (random or constant ready), then check the held outcome
  task automatic drain(input int rand_ready);
    int n;
    n = 0;
    while (exp_beats.size() > 0 && n < 100) begin
      res_ready = (rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    res_ready = 1'b0;
    chk("drain_timeout", (n < 100) ? 1 : 0, 1);
    m_phase = 2;
    check_done();
  endtask

  task automatic drain_with_stall();
    int n;
    n = 0;
    res_ready = 1'b1;
    while (exp_beats.size() == 4 && n < 10) begin step(); n++; end
    chk("stall_first_beat_timeout", (n < 10) ? 1 : 0, 1);
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_res_valid", res_valid, 1);
      chk("stall_res_cand", res_cand, exp_beats[0].cand);
      chk("stall_res_count", res_count, exp_beats[0].cnt);
    end
    drain(0);
  endtask

  // Monitor: vote responses, result beats and hold-while-stalled
  initial begin
    int    e;
    beat_t b;
    logic  prev_stall;
    logic [1:0] prev_cand;
    logic [CNT_W-1:0] prev_count;
    prev_stall = 1'b0;
    prev_cand  = '0;
    prev_count = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        if (vote_ack && vote_reject) chk("ack_reject_exclusive", 1, 0);
        if (vote_ack || vote_reject) begin
          if (exp_vote.size() == 0) chk("unexpected_vote_resp", 1, 0);
          else begin
            e = exp_vote.pop_front();
            chk("vote_ack", vote_ack, e);
          end
        end
        if (prev_stall) begin
          chk("hold_res_valid", res_valid, 1);
          chk("hold_res_cand", res_cand, prev_cand);
          chk("hold_res_count", res_count, prev_count);
        end
        if (res_valid && res_ready) begin
          if (exp_beats.size() == 0) chk("unexpected_beat", 1, 0);
          else begin
            b = exp_beats.pop_front();
            chk("beat_cand", res_cand, b.cand);
            chk("beat_count", res_count, b.cnt);
            chk("beat_last", res_last, b.last);
          end
        end
        prev_stall = res_valid && !res_ready;
        prev_cand  = res_cand;
        prev_count = res_count;
      end
    end
  end

  initial begin
    int nv;
    reset = 1'b0;
    vote_valid = 1'b0; vote_option = 2'd0; poll_close = 1'b0;
    poll_open = 1'b0; res_ready = 1'b0;
    model_clear();
    repeat (3) step();
    chk("rst_poll_active", poll_active, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_ack", vote_ack, 0);
    chk("rst_reject", vote_reject, 0);
    chk("rst_total", total_votes, 0);
    chk("rst_winner_valid", winner_valid, 0);
    chk("rst_tie", tie, 0);
    chk("rst_full", full, 0);
    chk("rst_winner", winner, 0);
    @(negedge clk); #2 reset = 1'b1;
    step();

    // A,B,B,C,B,D
    vote(0, 0); vote(1, 0); vote(1, 0); vote(2, 0); vote(1, 0); vote(3, 0);
    close_poll();
    drain(0);
    chk("t1_winner_const", winner, 1);
    open_poll();

    // Electorate limit: 8 accepted, 9th rejected
    for (int i = 0; i < 8; i++) vote(2, 0);
    chk("t2_full", full, 1);
    chk("t2_total", total_votes, 8);
    vote(2, 0);
    close_poll();
    drain(1);
    open_poll();

    // Tie between A and C
    vote(0, 0); vote(0, 0); vote(2, 0); vote(2, 0);
    close_poll();
    drain_with_stall();
    chk("t3_tie_const", tie, 1);
    open_poll();

    // Vote and close in the same cycle, then late votes
    vote(3, 1);
    vote(1, 0);
    drain(1);
    vote(0, 0);
    open_poll();

    // Randomized polls with stray open/close pulses
    for (int p = 0; p < 8; p++) begin
      nv = $urandom_range(0, 11);
      for (int v = 0; v < nv; v++) begin
        if ($urandom_range(0, 5) == 0) open_poll();
        vote($urandom_range(0, 3), (v == nv - 1 && $urandom_range(0, 1) == 1) ? 1 : 0);
      end
      if (m_phase == 0) close_poll();
      if ($urandom_range(0, 1) == 1) vote($urandom_range(0, 3), 0);
      close_poll();
      drain(1);
      if ($urandom_range(0, 1) == 1) vote($urandom_range(0, 3), 0);
      open_poll();
    end

    // Async reset in the middle of the result stream
    vote(1, 0); vote(1, 0);
    close_poll();
    res_ready = 1'b1;
    step();
    step();
    res_ready = 1'b0;
    step();
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_poll_active", poll_active, 1);
    chk("mid_rst_total", total_votes, 0);
    chk("mid_rst_winner_valid", winner_valid, 0);
    exp_beats.delete();
    model_clear();
    @(negedge clk); #2 reset = 1'b1;
    step();

    // poll_open while voting is ignored
    open_poll();
    vote(2, 0);
    chk("post_rst_total", total_votes, 1);
    close_poll();
    drain(1);
    open_poll();
    chk("reopen_total", total_votes, 0);
    chk("reopen_winner_valid", winner_valid, 0);
    close_poll();
    drain(0);
    chk("zero_poll_tie_const", tie, 1);

    repeat (2) step();
    chk("vote_queue_empty", exp_vote.size(), 0);
    chk("beat_queue_empty", exp_beats.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
